squash_input_conditioner: RTL and testbench

- Front-end stage that drives the game core's control inputs: pause_n, new_game_n, up_key_n, down_key_n.
- Takes raw, asynchronous, bouncy active-low board buttons and makes them safe for the game core.
- Per button: 2-FF synchronises, then debounces with a counter.
- Pause button becomes a toggled run/pause level; new-game button becomes a one-clock active-low pulse.
- Outputs connect 1:1 to the game core inputs of the same names, all in the clk domain.

---
 rtl/squash_input_conditioner.sv | 211 +++++++++++++++++++++
 tb/tb_squash_input_conditioner.sv | 383 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/squash_input_conditioner.sv
// -----------------------------------------------------------------------------
// squash_input_conditioner
//
// Conditions the four raw board buttons before they reach the squash game
// core. Each button is first synchronised into clk with two flops, then
// debounced by a counter. The debounced levels become the core's control
// inputs:
//   - pause:    a run/pause toggle, or a momentary level when the toggle
//               option is not built
//   - new game: a one-clock active-low pulse for each accepted press
//   - up/down:  debounced levels, both forced released while both are held
//
// Build option:
//   SQUASH_PAUSE_TOGGLE_EN  defined   -> each pause press toggles run/pause,
//                                        and a new-game press always resumes.
//                           undefined -> pause_n follows the debounced pause
//                                        button (paused only while held).
//
// Parameters:
//   DEBOUNCE_CYCLES  consecutive stable clocks needed to accept a new level
//                    (minimum 2)
//   CNT_W            debounce counter width, 2**CNT_W > DEBOUNCE_CYCLES
//
// Ports:
//   clk             in   pixel clock shared with the game core
//   reset           in   synchronous, active-high
//   btn_pause_n     in   raw pause button, active-low, asynchronous
//   btn_new_game_n  in   raw new-game button, active-low, asynchronous
//   btn_up_n        in   raw up button, active-low, asynchronous
//   btn_down_n      in   raw down button, active-low, asynchronous
//   pause_n         out  0 = game paused, registered
//   new_game_n      out  one-clock low pulse per accepted press, registered
//   up_key_n        out  debounced up level, active-low, registered
//   down_key_n      out  debounced down level, active-low, registered
// -----------------------------------------------------------------------------
module squash_input_conditioner #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int CNT_W           = 18
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_pause_n,
  input  logic btn_new_game_n,
  input  logic btn_up_n,
  input  logic btn_down_n,
  output logic pause_n,
  output logic new_game_n,
  output logic up_key_n,
  output logic down_key_n
);

  localparam int NB          = 4;
  localparam int BTN_PAUSE   = 0;
  localparam int BTN_NEWGAME = 1;
  localparam int BTN_UP      = 2;
  localparam int BTN_DOWN    = 3;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [NB-1:0]    raw;
  logic [NB-1:0]    s1;
  logic [NB-1:0]    s2;
  logic [NB-1:0]    st;
  logic [NB-1:0]    st_nxt;
  logic [CNT_W-1:0] cnt     [NB];
  logic [CNT_W-1:0] cnt_nxt [NB];

  assign raw = {btn_down_n, btn_up_n, btn_new_game_n, btn_pause_n};

  // ---------------------------------------------------------------------------
  // Two-flop synchronisers. Reset to 1 so every button reads as released.
  // ---------------------------------------------------------------------------
  // NOTE: clocked state uses non-blocking (<=) so every flop samples the
  // pre-edge value of its source; blocking here would collapse s1/s2 into one.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1 <= '1;
      s2 <= '1;
    end else begin
      s1 <= raw;
      s2 <= s1;
    end
  end

  // ---------------------------------------------------------------------------
  // Debounce. A level is accepted only after DEBOUNCE_CYCLES consecutive
  // clocks of disagreement with the stable state; any sample that matches
  // the stable state clears the count, so a bounce earns no partial credit.
  // The counter stops at CNT_LAST and can never wrap.
  // ---------------------------------------------------------------------------
  // NOTE: every combinational output is given a default before the branches,
  // so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    st_nxt = st;
    for (int b = 0; b < NB; b++) begin
      cnt_nxt[b] = '0;
      if (s2[b] != st[b]) begin
        if (cnt[b] == CNT_LAST) begin
          st_nxt[b] = s2[b];
        end else begin
          cnt_nxt[b] = cnt[b] + 1'b1;
        end
      end
    end
  end

  // NOTE: cnt is a handful of flops, not a RAM, so it is reset with the rest
  // of the state; a reset mid-debounce must discard any partial count.
  always_ff @(posedge clk) begin
    if (reset) begin
      st  <= '1;
      cnt <= '{default: '0};
    end else begin
      st  <= st_nxt;
      cnt <= cnt_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Press qualification. The stable state resets to "released", so a button
  // held through reset would otherwise look like a fresh press once its low
  // level is accepted. A press detector is armed only after it has seen a
  // genuine released sample: s2 carries real button data from the second
  // clock after reset, tracked by sync_vld.
  // ---------------------------------------------------------------------------
  logic [1:0] sync_vld;

  always_ff @(posedge clk) begin
    if (reset) sync_vld <= 2'b00;
    else       sync_vld <= {sync_vld[0], 1'b1};
  end

  logic newgame_prev;
  logic newgame_armed;
  logic press_newgame;

  assign press_newgame = newgame_armed & newgame_prev & ~st[BTN_NEWGAME];

  always_ff @(posedge clk) begin
    if (reset) begin
      newgame_prev  <= 1'b1;
      newgame_armed <= 1'b0;
      new_game_n    <= 1'b1;
    end else begin
      newgame_prev  <= st[BTN_NEWGAME];
      newgame_armed <= newgame_armed |
                       (sync_vld[1] & s2[BTN_NEWGAME] & st[BTN_NEWGAME]);
      new_game_n    <= ~press_newgame;
    end
  end

  // ---------------------------------------------------------------------------
  // Pause.
  // ---------------------------------------------------------------------------
`ifdef SQUASH_PAUSE_TOGGLE_EN
  logic pause_prev;
  logic pause_armed;
  logic press_pause;

  assign press_pause = pause_armed & pause_prev & ~st[BTN_PAUSE];

  always_ff @(posedge clk) begin
    if (reset) begin
      pause_prev  <= 1'b1;
      pause_armed <= 1'b0;
    end else begin
      pause_prev  <= st[BTN_PAUSE];
      pause_armed <= pause_armed |
                     (sync_vld[1] & s2[BTN_PAUSE] & st[BTN_PAUSE]);
    end
  end

  // pause_n is the paused flag held inverted in its own flop, so the output
  // is registered with no logic behind it. A new-game press outranks a
  // simultaneous pause press: a new game always starts running.
  always_ff @(posedge clk) begin
    if (reset) begin
      pause_n <= 1'b1;
    end else if (press_newgame) begin
      pause_n <= 1'b1;
    end else if (press_pause) begin
      pause_n <= ~pause_n;
    end
  end
`else
  // Momentary pause: paused only while the debounced button is held.
  always_ff @(posedge clk) begin
    if (reset) pause_n <= 1'b1;
    else       pause_n <= st[BTN_PAUSE];
  end
`endif

  // ---------------------------------------------------------------------------
  // Paddle keys. With both keys held, both are reported released so the
  // paddle stays still instead of depending on the core's priority.
  // ---------------------------------------------------------------------------
  logic both_pressed;

  assign both_pressed = ~st[BTN_UP] & ~st[BTN_DOWN];

  always_ff @(posedge clk) begin
    if (reset) begin
      up_key_n   <= 1'b1;
      down_key_n <= 1'b1;
    end else begin
      up_key_n   <= st[BTN_UP]   | both_pressed;
      down_key_n <= st[BTN_DOWN] | both_pressed;
    end
  end

endmodule

// File: tb/tb_squash_input_conditioner.sv
// -----------------------------------------------------------------------------
// tb_squash_input_conditioner
//
// Self-checking bench for squash_input_conditioner with DEBOUNCE_CYCLES = 4.
// Each test task drives the raw buttons just after a rising edge and, at
// the moment it drives an edge, pushes the output change that edge must
// cause (cycle number, output, level) onto a scoreboard queue. tick()
// advances one clock and applies any changes due on that cycle to the
// expected output vector; the test task then compares the whole output
// vector every clock, so both missing and spurious changes are caught.
//
// A raw edge driven after clock edge T appears on the outputs at edge T+7:
// 2 synchroniser clocks + 4 debounce clocks + 1 output register.
// Define SQUASH_PAUSE_TOGGLE_EN for both bench and DUT to cover toggle pause.
// -----------------------------------------------------------------------------
module tb_squash_input_conditioner;

  localparam int DB  = 4;
  localparam int LAT = DB + 3;

  localparam int O_PAUSE = 0;
  localparam int O_NG    = 1;
  localparam int O_UP    = 2;
  localparam int O_DOWN  = 3;

  logic clk = 1'b0;
  logic reset;
  logic btn_pause_n;
  logic btn_new_game_n;
  logic btn_up_n;
  logic btn_down_n;
  logic pause_n;
  logic new_game_n;
  logic up_key_n;
  logic down_key_n;

  always #5 clk = ~clk;

  squash_input_conditioner #(
    .DEBOUNCE_CYCLES (DB),
    .CNT_W           (3)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .btn_pause_n    (btn_pause_n),
    .btn_new_game_n (btn_new_game_n),
    .btn_up_n       (btn_up_n),
    .btn_down_n     (btn_down_n),
    .pause_n        (pause_n),
    .new_game_n     (new_game_n),
    .up_key_n       (up_key_n),
    .down_key_n     (down_key_n)
  );

  logic [3:0] outs;
  assign outs = {down_key_n, up_key_n, new_game_n, pause_n};

  typedef struct {
    int   at;
    int   idx;
    logic val;
  } exp_ev_t;

  exp_ev_t    sb[$];
  logic [3:0] exp_outs;
  int         cyc;
  int         checks;
  int         fails;

  task automatic expect_at(input int at, input int idx, input logic val);
    sb.push_back('{at: at, idx: idx, val: val});
  endtask

  // One clock; sample 1 time unit after the edge, away from it.
  task automatic tick();
    @(posedge clk);
    cyc++;
    #1;
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].at == cyc) begin
        exp_outs[sb[i].idx] = sb[i].val;
        sb.delete(i);
      end
    end
  endtask

  task automatic test_reset();
    reset          = 1'b1;
    btn_pause_n    = 1'b0;
    btn_new_game_n = 1'b0;
    btn_up_n       = 1'b0;
    btn_down_n     = 1'b0;
    exp_outs       = 4'b1111;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if (outs !== exp_outs) begin
        fails++;
        $display("FAIL reset_hold cyc=%0d outs=%b expected=%b", cyc, outs, exp_outs);
      end
    end
    // Buttons held through reset: up/down both held stay forced released,
    // new game must not pulse, and a momentary pause follows the button.
    reset = 1'b0;
`ifndef SQUASH_PAUSE_TOGGLE_EN
    expect_at(cyc + LAT, O_PAUSE, 1'b0);
`endif
    for (int k = 0; k < 30; k++) begin
      if (k == 15) begin
        btn_pause_n    = 1'b1;
        btn_new_game_n = 1'b1;
        btn_up_n       = 1'b1;
        btn_down_n     = 1'b1;
`ifndef SQUASH_PAUSE_TOGGLE_EN
        expect_at(cyc + LAT, O_PAUSE, 1'b1);
`endif
      end
      tick();
      checks++;
      if (outs !== exp_outs) begin
        fails++;
        $display("FAIL reset_held_buttons cyc=%0d outs=%b expected=%b", cyc, outs, exp_outs);
      end
    end
    // After a release, a fresh press must pulse new_game_n.
    for (int k = 0; k < 25; k++) begin
      if (k == 0) begin
        btn_new_game_n = 1'b0;
        expect_at(cyc + LAT,     O_NG, 1'b0);
        expect_at(cyc + LAT + 1, O_NG, 1'b1);
      end
      if (k == 12) btn_new_game_n = 1'b1;
      tick();
      checks++;
      if (outs !== exp_outs) begin
        fails++;
        $display("FAIL reset_repress cyc=%0d outs=%b expected=%b", cyc, outs, exp_outs);
      end
    end
  endtask

  task automatic test_clean_press();
    for (int k = 0; k < 35; k++) begin
      if (k == 0) begin
        btn_up_n = 1'b0;
        expect_at(cyc + LAT, O_UP, 1'b0);
      end
      if (k == 20) begin
        btn_up_n = 1'b1;
        expect_at(cyc + LAT, O_UP, 1'b1);
      end
      tick();
      checks++;
      if (outs !== exp_outs) begin
        fails++;
        $display("FAIL clean_press cyc=%0d outs=%b expected=%b", cyc, outs, exp_outs);
      end
    end
  endtask

  task automatic test_bounce();
    // 0,1,0,1 every 2 clocks, then 0 for good at k == 8.
    for (int k = 0; k < 25; k++) begin
      if (k <= 8 && k % 2 == 0) begin
        btn_down_n = ((k / 2) % 2 == 1);
        if (k == 8) expect_at(cyc + LAT, O_DOWN, 1'b0);
      end
      tick();
      checks++;
      if (outs !== exp_outs) begin
        fails++;
        $display("FAIL bounce cyc=%0d outs=%b expected=%b", cyc, outs, exp_outs);
      end
    end
    for (int k = 0; k < 12; k++) begin
      if (k == 0) begin
        btn_down_n = 1'b1;
        expect_at(cyc + LAT, O_DOWN, 1'b1);
      end
      tick();
      checks++;
      if (outs !== exp_outs) begin
        fails++;
        $display("FAIL bounce_release cyc=%0d outs=%b expected=%b", cyc, outs, exp_outs);
      end
    end
  endtask

  task automatic test_debounce_boundary();
    // A DB-1 clock pulse is rejected; a DB clock pulse is accepted.
    for (int k = 0; k < 30; k++) begin
      if (k == 0)  btn_down_n = 1'b0;
      if (k == 3)  btn_down_n = 1'b1;
      if (k == 10) begin
        btn_down_n = 1'b0;
        expect_at(cyc + LAT, O_DOWN, 1'b0);
      end
      if (k == 14) begin
        btn_down_n = 1'b1;
        expect_at(cyc + LAT, O_DOWN, 1'b1);
      end
      tick();
      checks++;
      if (outs !== exp_outs) begin
        fails++;
        $display("FAIL debounce_boundary cyc=%0d outs=%b expected=%b", cyc, outs, exp_outs);
      end
    end
  endtask

  task automatic test_new_game();
    for (int k = 0; k < 95; k++) begin
      if (k == 0 || k == 70) begin
        btn_new_game_n = 1'b0;
        expect_at(cyc + LAT,     O_NG, 1'b0);
        expect_at(cyc + LAT + 1, O_NG, 1'b1);
      end
      if (k == 50 || k == 80) btn_new_game_n = 1'b1;
      tick();
      checks++;
      if (outs !== exp_outs) begin
        fails++;
        $display("FAIL new_game cyc=%0d outs=%b expected=%b", cyc, outs, exp_outs);
      end
    end
  endtask

`ifdef SQUASH_PAUSE_TOGGLE_EN
  task automatic test_pause();
    for (int k = 0; k < 115; k++) begin
      case (k)
        0: begin
          btn_pause_n = 1'b0;
          expect_at(cyc + LAT, O_PAUSE, 1'b0);
        end
        25: begin
          btn_pause_n = 1'b0;
          expect_at(cyc + LAT, O_PAUSE, 1'b1);
        end
        50: begin
          btn_pause_n = 1'b0;
          expect_at(cyc + LAT, O_PAUSE, 1'b0);
        end
        10, 35, 60: btn_pause_n = 1'b1;
        70: begin
          // New game while paused resumes on the same clock as the pulse.
          btn_new_game_n = 1'b0;
          expect_at(cyc + LAT,     O_PAUSE, 1'b1);
          expect_at(cyc + LAT,     O_NG,    1'b0);
          expect_at(cyc + LAT + 1, O_NG,    1'b1);
        end
        80: btn_new_game_n = 1'b1;
        90: begin
          // Simultaneous pause and new-game presses: new game wins.
          btn_pause_n    = 1'b0;
          btn_new_game_n = 1'b0;
          expect_at(cyc + LAT,     O_NG, 1'b0);
          expect_at(cyc + LAT + 1, O_NG, 1'b1);
        end
        100: begin
          btn_pause_n    = 1'b1;
          btn_new_game_n = 1'b1;
        end
        default: ;
      endcase
      tick();
      checks++;
      if (outs !== exp_outs) begin
        fails++;
        $display("FAIL pause_toggle cyc=%0d outs=%b expected=%b", cyc, outs, exp_outs);
      end
    end
  endtask
`else
  task automatic test_pause();
    for (int k = 0; k < 65; k++) begin
      case (k)
        0, 25: begin
          btn_pause_n = 1'b0;
          expect_at(cyc + LAT, O_PAUSE, 1'b0);
        end
        10: begin
          btn_pause_n = 1'b1;
          expect_at(cyc + LAT, O_PAUSE, 1'b1);
        end
        40: begin
          // New game has no effect on a momentary pause.
          btn_new_game_n = 1'b0;
          expect_at(cyc + LAT,     O_NG, 1'b0);
          expect_at(cyc + LAT + 1, O_NG, 1'b1);
        end
        50: begin
          btn_pause_n    = 1'b1;
          btn_new_game_n = 1'b1;
          expect_at(cyc + LAT, O_PAUSE, 1'b1);
        end
        default: ;
      endcase
      tick();
      checks++;
      if (outs !== exp_outs) begin
        fails++;
        $display("FAIL pause_momentary cyc=%0d outs=%b expected=%b", cyc, outs, exp_outs);
      end
    end
  endtask
`endif

  task automatic test_up_down();
    for (int k = 0; k < 55; k++) begin
      case (k)
        0: begin
          btn_up_n = 1'b0;
          expect_at(cyc + LAT, O_UP, 1'b0);
        end
        12: begin
          // Down joins: both held, so up is forced back to released.
          btn_down_n = 1'b0;
          expect_at(cyc + LAT, O_UP, 1'b1);
        end
        25: begin
          btn_up_n = 1'b1;
          expect_at(cyc + LAT, O_DOWN, 1'b0);
        end
        40: begin
          btn_down_n = 1'b1;
          expect_at(cyc + LAT, O_DOWN, 1'b1);
        end
        default: ;
      endcase
      tick();
      checks++;
      if (outs !== exp_outs) begin
        fails++;
        $display("FAIL up_down cyc=%0d outs=%b expected=%b", cyc, outs, exp_outs);
      end
    end
  endtask

  task automatic test_reset_mid_debounce();
    // Reset partway through a debounce restarts the whole latency.
    for (int k = 0; k < 30; k++) begin
      if (k == 0) btn_up_n = 1'b0;
      if (k == 3) reset = 1'b1;
      if (k == 4) begin
        reset = 1'b0;
        expect_at(cyc + LAT, O_UP, 1'b0);
      end
      if (k == 15) begin
        btn_up_n = 1'b1;
        expect_at(cyc + LAT, O_UP, 1'b1);
      end
      tick();
      checks++;
      if (outs !== exp_outs) begin
        fails++;
        $display("FAIL reset_mid_debounce cyc=%0d outs=%b expected=%b", cyc, outs, exp_outs);
      end
    end
  endtask

  initial begin
    cyc    = 0;
    checks = 0;
    fails  = 0;
    test_reset();
    test_clean_press();
    test_bounce();
    test_debounce_boundary();
    test_new_game();
    test_pause();
    test_up_down();
    test_reset_mid_debounce();
    checks++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain pending=%0d expected=0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
